exwm_pipe: RTL and testbench

EXWM_PIPE -- requirements
Module: exwm_pipe

---
 rtl/exwm_pipe.sv | 169 ++++++++++++++++
 tb/tb_exwm_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exwm_pipe.sv
// exwm_pipe: single-stage execute unit with a registered output slot.
// ALU ops complete in one cycle; MUL/MULHU run on an iterative shift-add
// engine that consumes one multiplier bit per cycle.
module exwm_pipe #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            in_rwe,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [4:0]      out_rd,
    output logic            out_rwe,
    output logic            out_slt,
    output logic            out_sltu,
    output logic            out_zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_res;
    logic [4:0]        r_out_rd;
    logic              r_out_rwe;
    logic              r_out_slt;
    logic              r_out_sltu;
    logic              r_out_zero;

    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [SHW-1:0]    r_cnt;
    logic              r_mulhu;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_slt;
    logic              w_sltu;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_lo_nxt;

    assign in_ready  = !flush && (r_state != S_MUL) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (MUL_EN != 0) && ((in_op == 4'd10) || (in_op == 4'd11));
    assign w_slt     = $signed(in_a) < $signed(in_b);
    assign w_sltu    = in_a < in_b;
    assign w_shamt   = in_b[SHW-1:0];

    // Partial-product step: add multiplicand when the current multiplier bit
    // is set, then shift {carry, hi, lo} right by one.
    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_lo_nxt  = {w_sum[0], r_lo[XLEN-1:1]};

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_rd    = r_out_rd;
    assign out_rwe   = r_out_rwe;
    assign out_slt   = r_out_slt;
    assign out_sltu  = r_out_sltu;
    assign out_zero  = r_out_zero;
    assign busy      = (r_state == S_MUL);

    // Single-cycle ALU result; unsupported or reserved opcodes yield zero.
    always_comb begin
        w_alu = '0;
        case (in_op)
            4'd0:    w_alu = in_a + in_b;
            4'd1:    w_alu = in_a - in_b;
            4'd2:    w_alu = in_a << w_shamt;
            4'd3:    w_alu = in_a >> w_shamt;
            4'd4:    w_alu = $unsigned($signed(in_a) >>> w_shamt);
            4'd5:    w_alu = in_a & in_b;
            4'd6:    w_alu = in_a | in_b;
            4'd7:    w_alu = in_a ^ in_b;
            4'd8:    w_alu = {{(XLEN-1){1'b0}}, w_slt};
            4'd9:    w_alu = {{(XLEN-1){1'b0}}, w_sltu};
            default: w_alu = '0;
        endcase
    end

    // State register for the multiply sequencer.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: flush aborts; MUL runs until the bit counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
                S_MUL:   if (r_cnt == '0) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output slot and multiply datapath.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_rd    <= '0;
            r_out_rwe   <= 1'b0;
            r_out_slt   <= 1'b0;
            r_out_sltu  <= 1'b0;
            r_out_zero  <= 1'b0;
            r_mcand     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_mulhu     <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            // A consumed result is cleared unless replaced below in the same cycle.
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (r_state == S_MUL) begin
                r_hi  <= w_sum[XLEN:1];
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_out_valid <= 1'b1;
                    r_out_res   <= r_mulhu ? w_sum[XLEN:1] : w_lo_nxt;
                end
            end else if (w_accept) begin
                r_out_rd   <= in_rd;
                r_out_rwe  <= in_rwe;
                r_out_slt  <= w_slt;
                r_out_sltu <= w_sltu;
                r_out_zero <= (in_a == in_b);
                if (w_is_mul) begin
                    r_mcand <= in_a;
                    r_lo    <= in_b;
                    r_hi    <= '0;
                    r_cnt   <= SHW'(XLEN - 1);
                    r_mulhu <= in_op[0];
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_res   <= w_alu;
                end
            end
        end
    end

endmodule

// File: tb/tb_exwm_pipe.sv
// tb_exwm_pipe: randomized and directed checks of exwm_pipe against a
// cycle-level reference model built from plain arithmetic.
module tb_exwm_pipe;

    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      in_rd;
    logic            in_rwe;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [4:0]      out_rd;
    logic            out_rwe;
    logic            out_slt;
    logic            out_sltu;
    logic            out_zero;
    logic            busy;

    logic            in_valid2;
    logic            d0_in_ready;
    logic            d0_out_valid;
    logic [XLEN-1:0] d0_out_res;
    logic [4:0]      d0_out_rd;
    logic            d0_out_rwe;
    logic            d0_out_slt;
    logic            d0_out_sltu;
    logic            d0_out_zero;
    logic            d0_busy;

    always #5 CLK = ~CLK;

    exwm_pipe #(.XLEN(XLEN), .MUL_EN(1)) dut (
        .CLK(CLK), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_rwe(in_rwe),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_rd(out_rd), .out_rwe(out_rwe), .out_slt(out_slt),
        .out_sltu(out_sltu), .out_zero(out_zero), .busy(busy)
    );

    exwm_pipe #(.XLEN(XLEN), .MUL_EN(0)) dut0 (
        .CLK(CLK), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid2), .in_ready(d0_in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_rwe(in_rwe),
        .out_valid(d0_out_valid), .out_ready(1'b1), .out_res(d0_out_res),
        .out_rd(d0_out_rd), .out_rwe(d0_out_rwe), .out_slt(d0_out_slt),
        .out_sltu(d0_out_sltu), .out_zero(d0_out_zero), .busy(d0_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: a result slot plus a countdown for multiplies.
    logic        m_ov;
    int          m_cnt;
    logic [31:0] m_res;
    logic [31:0] m_pend;
    logic [4:0]  m_rd;
    logic        m_rwe;
    logic        m_slt;
    logic        m_sltu;
    logic        m_zero;
    logic        v2_req = 1'b0;

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit mul_en);
        logic [63:0] p;
        logic [31:0] fill;
        int          sh;
        sh   = int'(b & 32'd31);
        p    = 64'(a) * 64'(b);
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return a >> sh;
            4'd4:    return (a >> sh) | fill;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return mul_en ? p[31:0] : 32'd0;
            4'd11:   return mul_en ? p[63:32] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_cnt = 0; m_res = '0; m_pend = '0;
        m_rd = '0; m_rwe = 1'b0; m_slt = 1'b0; m_sltu = 1'b0; m_zero = 1'b0;
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input logic fl);
        logic exp_rdy;
        @(negedge CLK);
        in_valid  = v;   in_op = op; in_a = a; in_b = b;
        in_rd     = 5'($urandom); in_rwe = 1'($urandom);
        out_ready = ordy; flush = fl; in_valid2 = v2_req;
        #1;
        exp_rdy = !fl && (m_cnt == 0) && (!m_ov || ordy);
        check("in_ready", in_ready, exp_rdy);
        if (fl) begin
            m_ov = 1'b0; m_cnt = 0;
        end else begin
            if (m_ov && ordy) m_ov = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin m_ov = 1'b1; m_res = m_pend; end
            end else if (v && exp_rdy) begin
                m_rd = in_rd; m_rwe = in_rwe;
                m_slt = $signed(a) < $signed(b); m_sltu = a < b; m_zero = (a == b);
                if (op == 4'd10 || op == 4'd11) begin
                    m_cnt = XLEN; m_pend = ref_res(op, a, b, 1'b1);
                end else begin
                    m_ov = 1'b1; m_res = ref_res(op, a, b, 1'b1);
                end
            end
        end
        @(posedge CLK);
        #1;
        check("out_valid", out_valid, m_ov);
        check("busy", busy, m_cnt != 0);
        if (m_ov) begin
            check("out_res", out_res, m_res);
            check("out_rd", out_rd, m_rd);
            check("out_rwe", out_rwe, m_rwe);
            check("out_slt", out_slt, m_slt);
            check("out_sltu", out_sltu, m_sltu);
            check("out_zero", out_zero, m_zero);
        end
    endtask

    // Assert reset between edges, verify cleared outputs, release after one edge.
    task automatic async_reset();
        #1;
        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; flush = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_out_rd", out_rd, 5'd0);
        check("rst_out_rwe", out_rwe, 1'b0);
        check("rst_flags", {out_slt, out_sltu, out_zero}, 3'b000);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic mul_run(input logic [3:0] op, input logic [31:0] exp_res);
        int n;
        int nb;
        cyc(1'b1, op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        nb = busy ? 1 : 0;
        n  = 0;
        while (!out_valid && n < 40) begin
            cyc(1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 1'b0);
            n++;
            if (busy) nb++;
        end
        check("mul_latency", n + 1, 33);
        check("mul_busy_cycles", nb, 32);
        check("mul_result", out_res, exp_res);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_rd = '0; in_rwe = 1'b0; out_ready = 1'b1;
        model_reset();
        #2;
        async_reset();

        // Wrap-around add, latency one cycle.
        cyc(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        check("add_wrap_res", out_res, 32'd0);
        check("add_wrap_zero", out_zero, 1'b0);
        check("add_wrap_valid", out_valid, 1'b1);

        // Signed compare and arithmetic shift with oversized shift operand.
        cyc(1'b1, 4'd8, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
        check("slt_res", out_res, 32'd1);
        check("slt_flag", out_slt, 1'b1);
        check("sltu_flag", out_sltu, 1'b0);
        cyc(1'b1, 4'd4, 32'h8000_0000, 32'h23, 1'b1, 1'b0);
        check("sra_res", out_res, 32'hF000_0000);

        // Full-width multiply, low and high halves.
        mul_run(4'd10, 32'h0000_0001);
        mul_run(4'd11, 32'hFFFF_FFFE);

        // Backpressure: result held while downstream stalls.
        cyc(1'b1, 4'd0, 32'd10, 32'd20, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'd0, $urandom, $urandom, 1'b0, 1'b0);
            check("hold_res", out_res, 32'd30);
            check("hold_ready", in_ready, 1'b0);
        end
        cyc(1'b1, 4'd0, 32'd7, 32'd8, 1'b1, 1'b0);
        check("release_res", out_res, 32'd15);

        // Flush during a multiply.
        cyc(1'b1, 4'd10, 32'd123, 32'd456, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 1'b1);
        check("flush_busy", busy, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);
        cyc(1'b1, 4'd0, 32'd2, 32'd3, 1'b1, 1'b0);
        check("post_flush_add", out_res, 32'd5);

        // Reset during a multiply; MUL_EN=0 build treats op 10 as zero-result.
        cyc(1'b1, 4'd10, 32'd9, 32'd9, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        async_reset();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
            if (out_valid) seen++;
        end
        check("reset_no_result", seen, 0);
        v2_req = 1'b1;
        cyc(1'b0, 4'd10, 32'd5, 32'd7, 1'b1, 1'b0);
        v2_req = 1'b0;
        check("nomul_valid", d0_out_valid, 1'b1);
        check("nomul_res", d0_out_res, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            cyc($urandom_range(0, 3) != 0, op, a, b,
                $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
